// File: rtl/count_interval_arbiter.sv
// Round-robin arbiter that shares one up-counter among NREQ requesters,
// timing a latched interval for the winner and pulsing its done flag.
module count_interval_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic [NREQ-1:0]       iReq,
  input  logic [NREQ*WIDTH-1:0] iLen,
  input  logic                  iAbort,
  output logic [NREQ-1:0]       oGrant,
  output logic [NREQ-1:0]       oDone,
  output logic                  oBusy,
  output logic                  oCntEn,
  output logic [WIDTH-1:0]      oCount
);

  // state | meaning
  // IDLE  | waiting for a request; grant issued on the edge a request is seen
  // LATCH | first grant cycle: length latched, counter held at 0
  // RUN   | counting len cycles, grant held
  // DONE  | one-cycle done pulse to the last winner, grant dropped
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]  len_q, len_d;
  logic [WIDTH-1:0]  count_q, count_d;

  logic [WIDTH-1:0]  len_arr [NREQ];
  logic [PW-1:0]     cand    [NREQ];
  logic              sel_valid;
  logic [PW-1:0]     sel_idx;
  logic [WIDTH-1:0]  sel_len;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      len_arr[k] = iLen[k*WIDTH +: WIDTH];
      cand[k]    = PW'((int'(ptr_q) + k + 1) % NREQ);
    end
  end

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    sel_len   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!sel_valid && iReq[cand[k]]) begin
        sel_valid = 1'b1;
        sel_idx   = cand[k];
        sel_len   = len_arr[cand[k]];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (!iAbort && sel_valid) begin
          state_d = S_LATCH;
          grant_d = NREQ'(1) << sel_idx;
          ptr_d   = sel_idx;
          len_d   = sel_len;
          count_d = '0;
        end
      end
      S_LATCH: begin
        if (iAbort) begin
          state_d = S_IDLE;
          grant_d = '0;
          count_d = '0;
        end else if (len_q == '0) begin
          state_d = S_DONE;
          grant_d = '0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (iAbort) begin
          state_d = S_IDLE;
          grant_d = '0;
          count_d = '0;
        end else if (count_q == len_q - WIDTH'(1)) begin
          state_d = S_DONE;
          grant_d = '0;
          count_d = '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
        count_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(NREQ - 1);
      len_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      count_q <= count_d;
    end
  end

  // An abort arriving during DONE suppresses the pulse in that same cycle.
  assign oDone  = (state_q == S_DONE && !iAbort) ? (NREQ'(1) << ptr_q) : '0;
  assign oGrant = grant_q;
  assign oBusy  = (state_q != S_IDLE);
  assign oCntEn = (state_q == S_RUN);
  assign oCount = count_q;

endmodule

// File: tb/tb_count_interval_arbiter.sv
// Directed bench for count_interval_arbiter: latency, round-robin order,
// zero/max length, abort and asynchronous reset.
module tb_count_interval_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  iClock;
  logic                  iReset;
  logic [NREQ-1:0]       iReq;
  logic [NREQ*WIDTH-1:0] iLen;
  logic                  iAbort;
  logic [NREQ-1:0]       oGrant;
  logic [NREQ-1:0]       oDone;
  logic                  oBusy;
  logic                  oCntEn;
  logic [WIDTH-1:0]      oCount;

  int errors = 0;
  int checks = 0;

  count_interval_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .iClock (iClock),
    .iReset (iReset),
    .iReq   (iReq),
    .iLen   (iLen),
    .iAbort (iAbort),
    .oGrant (oGrant),
    .oDone  (oDone),
    .oBusy  (oBusy),
    .oCntEn (oCntEn),
    .oCount (oCount)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic apply_reset();
    iReset = 1'b0;
    iReq   = '0;
    iAbort = 1'b0;
    iLen   = '0;
    repeat (2) @(posedge iClock);
    #1;
    iReset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({oGrant, oDone, oBusy, oCntEn, oCount} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got grant=%b done=%b busy=%b cnten=%b count=%0d, want all 0",
               oGrant, oDone, oBusy, oCntEn, oCount);
    end
  endtask

  task automatic test_single();
    apply_reset();
    iLen = {8'd0, 8'd0, 8'd0, 8'd3};
    iReq = 4'b0001;
    tick();
    checks++;
    if (oGrant !== 4'b0001 || oCount !== 8'd0 || oCntEn !== 1'b0) begin
      errors++;
      $display("FAIL single_latch: got grant=%b count=%0d cnten=%b, want 0001 0 0", oGrant, oCount, oCntEn);
    end
    iReq = 4'b0000;
    iLen = {8'd0, 8'd0, 8'd0, 8'd7};
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (oGrant !== 4'b0001 || oCntEn !== 1'b1 || oCount !== WIDTH'(c) || oBusy !== 1'b1 || oDone !== 4'b0000) begin
        errors++;
        $display("FAIL single_run%0d: got grant=%b cnten=%b count=%0d busy=%b done=%b, want 0001 1 %0d 1 0000",
                 c, oGrant, oCntEn, oCount, oBusy, oDone, c);
      end
    end
    tick();
    checks++;
    if (oDone !== 4'b0001 || oGrant !== 4'b0000 || oCntEn !== 1'b0 || oCount !== 8'd0 || oBusy !== 1'b1) begin
      errors++;
      $display("FAIL single_done: got done=%b grant=%b cnten=%b count=%0d busy=%b, want 0001 0000 0 0 1",
               oDone, oGrant, oCntEn, oCount, oBusy);
    end
    tick();
    checks++;
    if (oDone !== 4'b0000 || oBusy !== 1'b0 || oGrant !== 4'b0000) begin
      errors++;
      $display("FAIL single_idle: got done=%b busy=%b grant=%b, want 0000 0 0000", oDone, oBusy, oGrant);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_g [5];
    exp_g[0] = 4'b0001;
    exp_g[1] = 4'b0010;
    exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000;
    exp_g[4] = 4'b0001;
    apply_reset();
    iLen = {8'd1, 8'd1, 8'd1, 8'd1};
    iReq = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++;
      if (oGrant !== exp_g[n]) begin
        errors++;
        $display("FAIL rr_grant%0d: got %b, want %b", n, oGrant, exp_g[n]);
      end
      tick();
      checks++;
      if (oCntEn !== 1'b1 || oGrant !== exp_g[n] || oCount !== 8'd0) begin
        errors++;
        $display("FAIL rr_run%0d: got cnten=%b grant=%b count=%0d, want 1 %b 0", n, oCntEn, oGrant, oCount, exp_g[n]);
      end
      tick();
      checks++;
      if (oDone !== exp_g[n] || oGrant !== 4'b0000) begin
        errors++;
        $display("FAIL rr_done%0d: got done=%b grant=%b, want %b 0000", n, oDone, oGrant, exp_g[n]);
      end
      tick();
      checks++;
      if (oGrant !== 4'b0000 || oBusy !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap%0d: got grant=%b busy=%b, want 0000 0", n, oGrant, oBusy);
      end
    end
    iReq = 4'b0000;
  endtask

  task automatic test_zero_len();
    apply_reset();
    iLen = {8'd5, 8'd0, 8'd5, 8'd5};
    iReq = 4'b0100;
    tick();
    checks++;
    if (oGrant !== 4'b0100 || oCntEn !== 1'b0) begin
      errors++;
      $display("FAIL zero_grant: got grant=%b cnten=%b, want 0100 0", oGrant, oCntEn);
    end
    iReq = 4'b0000;
    tick();
    checks++;
    if (oDone !== 4'b0100 || oGrant !== 4'b0000 || oCntEn !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: got done=%b grant=%b cnten=%b, want 0100 0000 0", oDone, oGrant, oCntEn);
    end
    tick();
    checks++;
    if (oDone !== 4'b0000 || oCntEn !== 1'b0 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL zero_idle: got done=%b cnten=%b busy=%b, want 0000 0 0", oDone, oCntEn, oBusy);
    end
  endtask

  task automatic test_abort();
    apply_reset();
    iLen   = {8'd3, 8'd3, 8'd10, 8'd3};
    iReq   = 4'b0010;
    iAbort = 1'b1;
    tick();
    checks++;
    if (oGrant !== 4'b0000 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle_block: got grant=%b busy=%b, want 0000 0", oGrant, oBusy);
    end
    iAbort = 1'b0;
    tick();
    checks++;
    if (oGrant !== 4'b0010) begin
      errors++;
      $display("FAIL abort_grant1: got %b, want 0010", oGrant);
    end
    iReq = 4'b0110;
    repeat (5) tick();
    checks++;
    if (oCount !== 8'd4 || oCntEn !== 1'b1) begin
      errors++;
      $display("FAIL abort_count4: got count=%0d cnten=%b, want 4 1", oCount, oCntEn);
    end
    iAbort = 1'b1;
    tick();
    checks++;
    if (oGrant !== 4'b0000 || oCount !== 8'd0 || oDone !== 4'b0000 || oBusy !== 1'b0 || oCntEn !== 1'b0) begin
      errors++;
      $display("FAIL abort_run: got grant=%b count=%0d done=%b busy=%b cnten=%b, want 0000 0 0000 0 0",
               oGrant, oCount, oDone, oBusy, oCntEn);
    end
    iAbort = 1'b0;
    tick();
    checks++;
    if (oGrant !== 4'b0100) begin
      errors++;
      $display("FAIL abort_next_rr: got %b, want 0100", oGrant);
    end
    iReq = 4'b0000;
    repeat (3) tick();
    checks++;
    if (oCount !== 8'd2 || oCntEn !== 1'b1) begin
      errors++;
      $display("FAIL abort_last_cycle: got count=%0d cnten=%b, want 2 1", oCount, oCntEn);
    end
    iAbort = 1'b1;
    tick();
    checks++;
    if (oDone !== 4'b0000 || oGrant !== 4'b0000 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL abort_priority: got done=%b grant=%b busy=%b, want 0000 0000 0", oDone, oGrant, oBusy);
    end
    iAbort = 1'b0;
    tick();
    checks++;
    if (oDone !== 4'b0000 || oBusy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_late_done: got done=%b busy=%b, want 0000 0", oDone, oBusy);
    end
  endtask

  task automatic test_max_len();
    apply_reset();
    iLen = {8'd0, 8'd0, 8'd0, 8'd255};
    iReq = 4'b0001;
    tick();
    iReq = 4'b0000;
    for (int c = 0; c < 255; c++) begin
      tick();
      checks++;
      if (oCount !== WIDTH'(c) || oCntEn !== 1'b1 || oDone !== 4'b0000) begin
        errors++;
        $display("FAIL max_count%0d: got count=%0d cnten=%b done=%b, want %0d 1 0000", c, oCount, oCntEn, oDone, c);
      end
    end
    tick();
    checks++;
    if (oDone !== 4'b0001 || oCount !== 8'd0 || oCntEn !== 1'b0) begin
      errors++;
      $display("FAIL max_done: got done=%b count=%0d cnten=%b, want 0001 0 0", oDone, oCount, oCntEn);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    iLen = {8'd3, 8'd10, 8'd3, 8'd3};
    iReq = 4'b0100;
    tick();
    iReq = 4'b0000;
    repeat (6) tick();
    checks++;
    if (oCount !== 8'd5 || oGrant !== 4'b0100) begin
      errors++;
      $display("FAIL mid_count5: got count=%0d grant=%b, want 5 0100", oCount, oGrant);
    end
    iReset = 1'b0;
    #1;
    checks++;
    if ({oGrant, oDone, oBusy, oCntEn, oCount} !== '0) begin
      errors++;
      $display("FAIL mid_async_reset: got grant=%b done=%b busy=%b cnten=%b count=%0d, want all 0",
               oGrant, oDone, oBusy, oCntEn, oCount);
    end
    iReq = 4'b1111;
    @(posedge iClock);
    #1;
    checks++;
    if (oGrant !== 4'b0000 || oDone !== 4'b0000) begin
      errors++;
      $display("FAIL mid_held_reset: got grant=%b done=%b, want 0000 0000", oGrant, oDone);
    end
    iReset = 1'b1;
    tick();
    checks++;
    if (oGrant !== 4'b0001) begin
      errors++;
      $display("FAIL mid_after_release: got grant=%b, want 0001", oGrant);
    end
    iReq = 4'b0000;
  endtask

  initial begin
    iReset = 1'b0;
    iReq   = '0;
    iLen   = '0;
    iAbort = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_len();
    test_abort();
    test_max_len();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
